fetch_ctrl: RTL and testbench

Fetch sequencer for the IF stage. It owns the program counter and drives a variable-latency instruction memory over a single-outstanding request/response handshake. It handles redirects from later stages, discarding wrong-path responses that are still in flight. It presents fetched instructions to the IF/ID boundary through a valid/ready handshake, so decode stalls back-pressure fetch.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

  // Canonical NOP (addi x0, x0, 0) shown on out_instr when nothing valid
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // First fetch address after reset
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, drives a single-outstanding
// variable-latency instruction memory, drops wrong-path responses after a
// redirect and hands fetched instructions to IF/ID over valid/ready.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0]  NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pcplus4,
  output logic [XLEN-1:0]  out_instr
);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             kill_q, kill_d;
  logic             imem_req_q, imem_req_d;
  logic [XLEN-1:0]  imem_addr_q, imem_addr_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_pc_q, out_pc_d;
  logic [XLEN-1:0]  out_pcplus4_q, out_pcplus4_d;
  logic [XLEN-1:0]  out_instr_q, out_instr_d;

  logic [XLEN-1:0]  redirect_target;
  logic [XLEN-1:0]  pc_plus4;
  logic             unused_redirect_lsbs;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Sequential increment wraps naturally modulo 2^XLEN.
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state and next-output logic; redirect always takes priority.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_pcplus4_d = out_pcplus4_q;
    out_instr_d   = out_instr_q;

    case (state_q)
      BOOT: begin
        // One dead cycle swallows any response left over from before reset.
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        state_d = ISSUE;
      end

      ISSUE: begin
        // The request just went out for the old pc; its response is now stale.
        if (redirect_valid) begin
          pc_d   = redirect_target;
          kill_d = 1'b1;
        end
        state_d = WAIT;
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (imem_rvalid) begin
            // Stale response arrives together with the redirect: drop it now.
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            // Response still in flight: mark it for discard. Only one is
            // ever outstanding, so repeated redirects just move the target.
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            // Wrong-path response; pc already holds the redirect target.
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            out_instr_d   = imem_rdata;
            out_pc_d      = pc_q;
            out_pcplus4_d = pc_plus4;
            out_valid_d   = 1'b1;
            pc_d          = pc_plus4;
            state_d       = VALID;
          end
        end
      end

      VALID: begin
        if (redirect_valid) begin
          // A redirect cancels the held instruction even if out_ready is high.
          out_valid_d = 1'b0;
          pc_d        = redirect_target;
          state_d     = ISSUE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ISSUE;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    // The request pulse and its address are registered on entry to ISSUE;
    // the address then stays put until the next request.
    imem_req_d  = (state_d == ISSUE);
    imem_addr_d = (state_d == ISSUE) ? pc_d : imem_addr_q;
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_pc_q      <= RESET_PC;
      out_pcplus4_q <= RESET_PC + XLEN'(4);
      out_instr_q   <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_pcplus4_q <= out_pcplus4_d;
      out_instr_q   <= out_instr_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_pcplus4 = out_pcplus4_q;
  assign out_instr   = out_instr_q;

  // Memory may only answer while a request is outstanding (WAIT). BOOT is
  // excluded because absorbing a leftover pre-reset response is its job.
  a_rvalid_only_when_waiting : assert property (
    @(posedge clk) disable iff (!reset)
      imem_rvalid |-> (state_q == WAIT || state_q == BOOT)
  );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a cycle table for the steady-state
// fetch stream and decode stall, then hand-written redirect/reset sequences.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model (latency in cycles from request cycle to rvalid cycle)
  int          mem_lat = 1;
  int          mem_cnt;
  logic        mem_pend;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // Manual override of the response bus for the reset corner case
  logic        manual = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  assign imem_rvalid = manual ? man_rvalid : mem_rvalid;
  assign imem_rdata  = manual ? man_rdata  : mem_rdata;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_instr(out_instr)
  );

  // Instruction stored at a given address
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return a + 32'h1000_0013;
  endfunction

  // Variable-latency instruction memory
  always @(posedge clk) begin
    if (!reset) begin
      mem_pend   <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_cnt    <= 0;
      mem_addr   <= 32'h0;
      mem_rdata  <= 32'h0;
    end else begin
      mem_rvalid <= 1'b0;
      if (imem_req) begin
        mem_addr <= imem_addr;
        if (mem_lat <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= imem_f(imem_addr);
          mem_pend   <= 1'b0;
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= mem_lat - 1;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= imem_f(mem_addr);
          mem_pend   <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},     {31'b0, imem_req},  32'h0);
    chk({tag, "_addr"},    imem_addr,          RST_PC);
    chk({tag, "_valid"},   {31'b0, out_valid}, 32'h0);
    chk({tag, "_pc"},      out_pc,             RST_PC);
    chk({tag, "_pcplus4"}, out_pcplus4,        RST_PC + 32'd4);
    chk({tag, "_instr"},   out_instr,          NOP);
  endtask

  // Ends at the release negedge, i.e. during the BOOT cycle
  task automatic reset_dut(input int lat, input string tag);
    mem_lat = lat;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset(tag);
    reset = 1'b1;
    $display("reset released (%s), memory latency %0d", tag, lat);
  endtask

  // Checks the current negedge first, then advances up to max_cyc-1 cycles
  task automatic expect_req(input string name, input logic [31:0] exp_addr,
                            input int max_cyc, output int nvalid);
    bit found = 0;
    nvalid = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (i > 0) @(negedge clk);
      if (imem_req) begin
        found = 1;
        break;
      end
      if (out_valid) nvalid++;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: no imem_req within %0d cycles, expected addr %h", name, max_cyc, exp_addr);
    end else begin
      $display("req %s addr=%h", name, imem_addr);
      chk({name, "_addr"}, imem_addr, exp_addr);
    end
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    bit found = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (i > 0) @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: out_valid not seen within %0d cycles, got 0 expected 1", name, max_cyc);
    end else begin
      $display("out %s pc=%h pc4=%h instr=%h", name, out_pc, out_pcplus4, out_instr);
    end
  endtask

  task automatic wait_rvalid(input string name, input int max_cyc);
    bit found = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (i > 0) @(negedge clk);
      if (imem_rvalid) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: imem_rvalid not seen within %0d cycles", name, max_cyc);
    end
  endtask

  // One-cycle redirect pulse; returns at the following negedge
  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    $display("redirect to %h", target);
  endtask

  typedef struct {
    logic        ready;   // out_ready driven during this cycle
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[23];
  int   nv;

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Steady stream with 1-cycle memory, then a 5-cycle decode stall at 0x10
    vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, NOP};
    vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, NOP};
    vecs[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00, imem_f(32'h00)};
    vecs[3]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, imem_f(32'h00)};
    vecs[4]  = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h00, imem_f(32'h00)};
    vecs[5]  = '{1'b1, 1'b0, 32'h04, 1'b1, 32'h04, imem_f(32'h04)};
    vecs[6]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h04, imem_f(32'h04)};
    vecs[7]  = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h04, imem_f(32'h04)};
    vecs[8]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h08, imem_f(32'h08)};
    vecs[9]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h08, imem_f(32'h08)};
    vecs[10] = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h08, imem_f(32'h08)};
    vecs[11] = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h0C, imem_f(32'h0C)};
    vecs[12] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h0C, imem_f(32'h0C)};
    vecs[13] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h0C, imem_f(32'h0C)};
    vecs[14] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h10, imem_f(32'h10)};
    vecs[15] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h10, imem_f(32'h10)};
    vecs[16] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h10, imem_f(32'h10)};
    vecs[17] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h10, imem_f(32'h10)};
    vecs[18] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h10, imem_f(32'h10)};
    vecs[19] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h10, imem_f(32'h10)};
    vecs[20] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h10, imem_f(32'h10)};
    vecs[21] = '{1'b1, 1'b0, 32'h14, 1'b0, 32'h10, imem_f(32'h10)};
    vecs[22] = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h14, imem_f(32'h14)};

    reset_dut(1, "rst0");
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      $display("vec %0d req=%0b addr=%h valid=%0b pc=%h pc4=%h instr=%h",
               i, imem_req, imem_addr, out_valid, out_pc, out_pcplus4, out_instr);
      chk($sformatf("v%0d_req", i),     {31'b0, imem_req},  {31'b0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),    imem_addr,          vecs[i].addr);
      chk($sformatf("v%0d_valid", i),   {31'b0, out_valid}, {31'b0, vecs[i].valid});
      chk($sformatf("v%0d_pc", i),      out_pc,             vecs[i].pc);
      chk($sformatf("v%0d_pcplus4", i), out_pcplus4,        vecs[i].pc + 32'd4);
      chk($sformatf("v%0d_instr", i),   out_instr,          vecs[i].instr);
      out_ready = vecs[i].ready;
    end

    // Redirect during a 4-cycle wait for 0x8: that response is dropped
    reset_dut(4, "rst1");
    @(negedge clk); expect_req("t3_req0", 32'h0, 10, nv);
    @(negedge clk); expect_req("t3_req4", 32'h4, 20, nv);
    @(negedge clk); expect_req("t3_req8", 32'h8, 20, nv);
    @(negedge clk); @(negedge clk);
    pulse_redirect(32'h0000_0203);
    expect_req("t3_req200", 32'h200, 20, nv);
    chk("t3_dropped_valids", nv, 0);
    @(negedge clk); wait_valid("t3_out200", 20);
    chk("t3_out_pc",      out_pc,      32'h200);
    chk("t3_out_pcplus4", out_pcplus4, 32'h204);
    chk("t3_out_instr",   out_instr,   imem_f(32'h200));

    // Redirect together with rvalid: response dropped, request goes to 0x40
    @(negedge clk); expect_req("t4_req204", 32'h204, 1, nv);
    @(negedge clk); wait_rvalid("t4_rvalid", 20);
    pulse_redirect(32'h40);
    chk("t4a_out_valid", {31'b0, out_valid}, 32'h0);
    expect_req("t4_req40", 32'h40, 1, nv);
    @(negedge clk); wait_valid("t4_out40", 20);
    chk("t4_out_pc40", out_pc, 32'h40);
    // Redirect in VALID with out_ready=1: no transfer, request goes to 0x80
    pulse_redirect(32'h80);
    chk("t4b_out_valid", {31'b0, out_valid}, 32'h0);
    expect_req("t4_req80", 32'h80, 1, nv);
    @(negedge clk); wait_valid("t4_out80", 20);
    chk("t4_out_pc80",    out_pc,    32'h80);
    chk("t4_out_instr80", out_instr, imem_f(32'h80));

    // Wrap-around at the top of the address space
    pulse_redirect(32'hFFFF_FFFC);
    expect_req("t5_reqtop", 32'hFFFF_FFFC, 1, nv);
    @(negedge clk); wait_valid("t5_outtop", 20);
    chk("t5_out_pc",      out_pc,      32'hFFFF_FFFC);
    chk("t5_out_pcplus4", out_pcplus4, 32'h0);
    chk("t5_out_instr",   out_instr,   imem_f(32'hFFFF_FFFC));
    @(negedge clk); expect_req("t5_wrap", 32'h0, 1, nv);

    // Reset during WAIT; stale response lands in the BOOT cycle
    manual = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset("t6_rst");
    reset      = 1'b1;
    man_rvalid = 1'b1;
    man_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    man_rvalid = 1'b0;
    chk("t6_req",   {31'b0, imem_req},  32'h1);
    chk("t6_addr",  imem_addr,          RST_PC);
    chk("t6_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_instr", out_instr,          NOP);
    chk("t6_pc",    out_pc,             RST_PC);
    @(negedge clk);
    man_rvalid = 1'b1;
    man_rdata  = 32'h00A0_0093;
    @(negedge clk);
    man_rvalid = 1'b0;
    $display("t6 first fetch valid=%0b pc=%h instr=%h", out_valid, out_pc, out_instr);
    chk("t6_f_valid", {31'b0, out_valid}, 32'h1);
    chk("t6_f_pc",    out_pc,             RST_PC);
    chk("t6_f_instr", out_instr,          32'h00A0_0093);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_fetch_ctrl
